aes_round_sequencer: RTL and testbench
======================================

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter: NR, 10, number of cipher rounds; the legal values are 10, 12 and 14.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: start_valid  input  1  a block (plaintext plus key) is ready to be ciphered.
REQ-005 Port: start_ready  output  1  sequencer can accept a block; start accepted when start_valid&&start_ready at a clk edge.
REQ-006 Port: abort  input  1  synchronous cancel of the current operation.
REQ-007 Port: ld_sel  output  1  AddRoundKey state-input mux: 1=plaintext, 0=round-function output.
REQ-008 Port: sub_en  output  1  enables the SubBytes/ShiftRows path into AddRoundKey.
REQ-009 Port: mix_en  output  1  includes MixColumns in the round function; 0 = bypass.
REQ-010 Port: rk_idx  output  4  round-key index presented to the key store for the current AddRoundKey.
REQ-011 Port: round  output  4  current round number (0 = initial key add).
REQ-012 Port: busy  output  1  high in INIT and ROUND.
REQ-013 Port: cap_en  output  1  one-cycle strobe; the AddRoundKey register holds ciphertext this cycle.
REQ-014 Port: done_valid  output  1  ciphertext captured, awaiting acknowledge.
REQ-015 Port: done_ready  input  1  downstream acknowledge of the completion.

Function
REQ-016 FSM states SHALL be IDLE, INIT, ROUND and DONE; all outputs SHALL be decoded from the registered state and counter only (Moore, no input-to-output combinational path).
REQ-017 IDLE: start_ready=1; all other outputs=0; on an accepted start, next state INIT.
REQ-018 INIT (exactly 1 cycle): ld_sel=1, rk_idx=0, round=0, busy=1, sub_en=0, mix_en=0; next state ROUND with round counter=1.
REQ-019 ROUND (exactly NR cycles): ld_sel=0, sub_en=1, busy=1, rk_idx=round=counter; mix_en=1 for counter<NR and 0 for counter==NR.
REQ-020 In ROUND, the counter SHALL increment by 1 per cycle; when counter==NR, next state DONE.
REQ-021 DONE: cap_en=1 in the first DONE cycle only; done_valid=1 for every DONE cycle; busy=0, start_ready=0.
REQ-022 In DONE, done_ready=1 at a clk edge SHALL move the FSM to IDLE; otherwise it SHALL hold in DONE indefinitely.
REQ-023 The counter SHALL never exceed NR and SHALL never wrap; the counter and rk_idx SHALL be 0 outside INIT/ROUND.
REQ-024 start_valid SHALL be ignored in all states except IDLE (no queuing); back-to-back operation needs one IDLE cycle between blocks.
REQ-025 abort=1 at a clk edge in any state SHALL force IDLE and counter=0 on the next cycle; abort has priority over start and done_ready.
REQ-026 If abort and start_valid are both high in IDLE, the start SHALL NOT be accepted.
REQ-027 Latency: start accepted at edge E gives INIT at E+1, ROUND 1..NR at E+2..E+NR+1, and DONE/cap_en at E+NR+2.

Reset
REQ-028 While rst=0, the FSM SHALL be IDLE and the counter 0, immediately and without waiting for clk.
REQ-029 Reset values SHALL be: start_ready=1; ld_sel, sub_en, mix_en, busy, cap_en, done_valid=0; rk_idx, round=0.
REQ-030 Reset asserted mid-operation SHALL abandon the block with no cap_en and no done_valid; operation resumes from IDLE after rst deasserts.

Verification
REQ-031 NR=10, single start at edge 0 -> cycle 1 ld_sel=1/rk_idx=0; cycles 2..11 rk_idx=1..10, mix_en=1 on cycles 2..10 and 0 on cycle 11; cycle 12 cap_en=1 and done_valid=1.
REQ-032 done_ready held low for 5 cycles after DONE -> done_valid stays 1 for all 5 cycles, cap_en high only in the first; done_ready=1 -> IDLE and start_ready=1 next cycle.
REQ-033 abort at ROUND counter=4 -> next cycle IDLE, busy=0, rk_idx=0, no cap_en; a new start then runs the full 12-cycle sequence.
REQ-034 rst pulsed low asynchronously during ROUND 7 -> outputs reach reset values before the next clk edge; no done_valid.
REQ-035 start_valid held high continuously through a block -> exactly one acceptance per IDLE visit; start_ready=0 throughout INIT, ROUND and DONE.
REQ-036 NR=14 -> 14 ROUND cycles with rk_idx=1..14, mix_en=0 only at 14, cap_en at edge 16.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// AES round sequencer.
// This module produces the datapath controls for an iterative AES encryption
// core:
//   * an initial AddRoundKey cycle;
//   * NR round cycles, with MixColumns dropped on the last round;
//   * a completion handshake with a single capture strobe.
// Every output is decoded from registered state only, so the module is a pure
// Moore machine.
module aes_round_sequencer #(
   parameter int NR = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_valid,
   output logic       start_ready,
   input  logic       abort,
   output logic       ld_sel,
   output logic       sub_en,
   output logic       mix_en,
   output logic [3:0] rk_idx,
   output logic [3:0] round,
   output logic       busy,
   output logic       cap_en,
   output logic       done_valid,
   input  logic       done_ready
);

   // Last round number. It must be 10, 12 or 14, so it always fits in 4 bits.
   localparam logic [3:0] LAST_ROUND = 4'(NR);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INIT  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg,   cnt_next;
   // Set only for the first DONE cycle; this flag drives the capture strobe.
   logic       first_reg, first_next;

   // State, round counter and first-DONE flag.
   // Reset clears them at once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         first_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         first_reg <= first_next;
      end
   end

   // Next-state logic.
   // Abort overrides both start and done_ready.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      first_next = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = 4'd0;
            if (start_valid) begin
               state_next = INIT;
            end
         end
         INIT: begin
            state_next = ROUND;
            cnt_next   = 4'd1;
         end
         ROUND: begin
            if (cnt_reg == LAST_ROUND) begin
               state_next = DONE;
               cnt_next   = 4'd0;
               first_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
         DONE: begin
            cnt_next = 4'd0;
            if (done_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
      if (abort) begin
         state_next = IDLE;
         cnt_next   = 4'd0;
         first_next = 1'b0;
      end
   end

   // Output decode.
   // It uses only the registered state, the counter and the first-DONE flag.
   always_comb begin
      start_ready = 1'b0;
      ld_sel      = 1'b0;
      sub_en      = 1'b0;
      mix_en      = 1'b0;
      rk_idx      = 4'd0;
      round       = 4'd0;
      busy        = 1'b0;
      cap_en      = 1'b0;
      done_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            start_ready = 1'b1;
         end
         INIT: begin
            ld_sel = 1'b1;
            busy   = 1'b1;
         end
         ROUND: begin
            sub_en = 1'b1;
            busy   = 1'b1;
            rk_idx = cnt_reg;
            round  = cnt_reg;
            mix_en = (cnt_reg != LAST_ROUND);
         end
         DONE: begin
            done_valid = 1'b1;
            cap_en     = first_reg;
         end
         default: begin
            start_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed testbench for aes_round_sequencer.
// Two instances are checked: NR=10 (dut index 0) and NR=14 (dut index 1).
module tb_aes_round_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       a_sv = 1'b0, a_abort = 1'b0, a_dr = 1'b0;
   logic       a_sr, a_ld, a_sub, a_mix, a_busy, a_cap, a_dv;
   logic [3:0] a_rk, a_round;

   logic       b_sv = 1'b0, b_abort = 1'b0, b_dr = 1'b0;
   logic       b_sr, b_ld, b_sub, b_mix, b_busy, b_cap, b_dv;
   logic [3:0] b_rk, b_round;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   aes_round_sequencer #(.NR(10)) u_dut10 (
      .clk(clk), .rst(rst),
      .start_valid(a_sv), .start_ready(a_sr), .abort(a_abort),
      .ld_sel(a_ld), .sub_en(a_sub), .mix_en(a_mix),
      .rk_idx(a_rk), .round(a_round), .busy(a_busy),
      .cap_en(a_cap), .done_valid(a_dv), .done_ready(a_dr)
   );

   aes_round_sequencer #(.NR(14)) u_dut14 (
      .clk(clk), .rst(rst),
      .start_valid(b_sv), .start_ready(b_sr), .abort(b_abort),
      .ld_sel(b_ld), .sub_en(b_sub), .mix_en(b_mix),
      .rk_idx(b_rk), .round(b_round), .busy(b_busy),
      .cap_en(b_cap), .done_valid(b_dv), .done_ready(b_dr)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Samples outputs 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input int w,
                             input int ld, input int sub, input int mix,
                             input int rk, input int rnd, input int bsy,
                             input int cap, input int dv, input int sr);
      if (w == 0) begin
         chk({tag, ".ld_sel"},      a_ld,    ld);
         chk({tag, ".sub_en"},      a_sub,   sub);
         chk({tag, ".mix_en"},      a_mix,   mix);
         chk({tag, ".rk_idx"},      a_rk,    rk);
         chk({tag, ".round"},       a_round, rnd);
         chk({tag, ".busy"},        a_busy,  bsy);
         chk({tag, ".cap_en"},      a_cap,   cap);
         chk({tag, ".done_valid"},  a_dv,    dv);
         chk({tag, ".start_ready"}, a_sr,    sr);
      end else begin
         chk({tag, ".ld_sel"},      b_ld,    ld);
         chk({tag, ".sub_en"},      b_sub,   sub);
         chk({tag, ".mix_en"},      b_mix,   mix);
         chk({tag, ".rk_idx"},      b_rk,    rk);
         chk({tag, ".round"},       b_round, rnd);
         chk({tag, ".busy"},        b_busy,  bsy);
         chk({tag, ".cap_en"},      b_cap,   cap);
         chk({tag, ".done_valid"},  b_dv,    dv);
         chk({tag, ".start_ready"}, b_sr,    sr);
      end
   endtask

   task automatic exp_idle(input string tag, input int w);
      check_outs(tag, w, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic exp_init(input string tag, input int w);
      check_outs(tag, w, 1, 0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic exp_round(input string tag, input int w, input int k, input int nr);
      check_outs($sformatf("%s.r%0d", tag, k), w, 0, 1, (k < nr) ? 1 : 0,
                 k, k, 1, 0, 0, 0);
   endtask

   task automatic exp_done(input string tag, input int w, input int first);
      check_outs(tag, w, 0, 0, 0, 0, 0, 0, first, 1, 0);
   endtask

   task automatic set_start(input int w, input logic v);
      if (w == 0) a_sv = v; else b_sv = v;
   endtask

   task automatic set_dr(input int w, input logic v);
      if (w == 0) a_dr = v; else b_dr = v;
   endtask

   // Sends one start, then checks INIT, every round and the first DONE cycle.
   task automatic run_block(input string tag, input int w, input int nr);
      set_start(w, 1'b1);
      tick();
      set_start(w, 1'b0);
      exp_init({tag, ".init"}, w);
      for (int k = 1; k <= nr; k++) begin
         tick();
         exp_round(tag, w, k, nr);
      end
      tick();
      exp_done({tag, ".done1"}, w, 1);
      $display("block %s dut=%0d nr=%0d reached DONE", tag, w, nr);
   endtask

   initial begin
      // Reset values are checked before the first clock edge.
      #3;
      exp_idle("rst_pre_clk", 0);
      exp_idle("rst_pre_clk14", 1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      exp_idle("idle_after_rst", 0);

      // Single block with a delayed acknowledge.
      run_block("t1", 0, 10);
      for (int i = 2; i <= 5; i++) begin
         tick();
         exp_done($sformatf("t1.hold%0d", i), 0, 0);
      end
      set_dr(0, 1'b1);
      tick();
      set_dr(0, 1'b0);
      exp_idle("t1.ack_idle", 0);
      tick();
      exp_idle("t1.idle2", 0);

      // Abort at round counter 4, then run a full block.
      a_sv = 1'b1;
      tick();
      a_sv = 1'b0;
      exp_init("t3.init", 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_round("t3", 0, k, 10);
      end
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      exp_idle("t3.abort_idle", 0);
      $display("abort at round 4 checked");
      run_block("t3b", 0, 10);
      set_dr(0, 1'b1);
      tick();
      set_dr(0, 1'b0);
      exp_idle("t3b.ack_idle", 0);

      // Abort and start in IDLE together: the start is not accepted.
      a_abort = 1'b1;
      a_sv    = 1'b1;
      tick();
      a_abort = 1'b0;
      a_sv    = 1'b0;
      exp_idle("t4.abort_start", 0);
      tick();
      exp_idle("t4.idle2", 0);

      // Asynchronous reset during round 7.
      a_sv = 1'b1;
      tick();
      a_sv = 1'b0;
      exp_init("t5.init", 0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_round("t5", 0, k, 10);
      end
      #3;
      rst = 1'b0;
      #1;
      exp_idle("t5.async_rst", 0);
      tick();
      exp_idle("t5.rst_held", 0);
      rst = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         exp_idle($sformatf("t5.post%0d", i), 0);
      end
      $display("async reset during round 7 checked");

      // start_valid held high: exactly one acceptance per IDLE visit.
      a_sv = 1'b1;
      tick();
      exp_init("t6.init", 0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_round("t6", 0, k, 10);
      end
      tick();
      exp_done("t6.done1", 0, 1);
      tick();
      exp_done("t6.done2", 0, 0);
      set_dr(0, 1'b1);
      tick();
      set_dr(0, 1'b0);
      exp_idle("t6.idle", 0);
      tick();
      exp_init("t6.reaccept", 0);
      a_sv = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_round("t6b", 0, k, 10);
      end
      tick();
      exp_done("t6b.done1", 0, 1);
      set_dr(0, 1'b1);
      tick();
      set_dr(0, 1'b0);
      exp_idle("t6b.idle", 0);
      $display("held start_valid checked");

      // NR=14 instance.
      run_block("t7", 1, 14);
      set_dr(1, 1'b1);
      tick();
      set_dr(1, 1'b0);
      exp_idle("t7.ack_idle", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
